// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-128 inverse cipher:
//   - aes_state_t      : control FSM state encoding
//   - gf_mul2 / gf_mul : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
//   - sbox / inv_sbox  : byte substitution, built from the field inverse and
//                        the affine map rather than a 256-entry table
//   - rcon             : round constant table, Rcon[1..10]
//   - get_byte/get_col : byte and column helpers; byte 0 sits at [127:120],
//                        column c at [127-32c -: 32]
//   - inv_key_step     : derive k(r) from k(r+1)
//   - fwd_key_step     : derive k(r+1) from k(r), used only when
//                        AES_DEC_KEY_FWD_EN is defined
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEXP  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } aes_state_t;

    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; each xtime step reduces by the AES polynomial.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_mul2(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 via an addition chain; 0 maps to 0,
    // which is exactly what the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, a);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, a);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, a);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, a);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, a);
        return gf_mul(x127, x127);
    endfunction

    // Forward affine map: t ^ rotl(t,1..4) ^ 0x63.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] t;
        t = gf_inv(a);
        return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]}
                 ^ {t[3:0], t[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine map: rotl(b,1) ^ rotl(b,3) ^ rotl(b,6) ^ 0x05, then invert.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] get_byte(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] s, input int c);
        return s[127-32*c -: 32];
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    // Undo one expansion step: the last three words fall out of pairwise XORs,
    // and the recovered w3 then yields w0.
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = get_col(k, 3) ^ get_col(k, 2);
        w2 = get_col(k, 2) ^ get_col(k, 1);
        w1 = get_col(k, 1) ^ get_col(k, 0);
        w0 = get_col(k, 0) ^ sub_rot_word(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w4, w5, w6, w7;
        w4 = get_col(k, 0) ^ sub_rot_word(get_col(k, 3)) ^ {rc, 24'h000000};
        w5 = w4 ^ get_col(k, 1);
        w6 = w5 ^ get_col(k, 2);
        w7 = w6 ^ get_col(k, 3);
        return {w4, w5, w6, w7};
    endfunction

endpackage

// File: rtl/aes_inv_mix_columns.sv
// ---------------------------------------------------------------------------
// aes_inv_mix_columns
// Combinational InvMixColumns over all four columns of a 128-bit state.
// Ports:
//   data_in  - in,  128: state before InvMixColumns
//   data_out - out, 128: state after InvMixColumns
// ---------------------------------------------------------------------------
module aes_inv_mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] data_in,
    output logic [127:0] data_out
);

    // Each column is multiplied by the circulant matrix {0e,0b,0d,09}.
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [31:0] col;
        logic [7:0]  s0, s1, s2, s3;

        assign col = get_col(data_in, c);
        assign s0  = col[31:24];
        assign s1  = col[23:16];
        assign s2  = col[15:8];
        assign s3  = col[7:0];

        assign data_out[127-32*c -: 32] = {
            gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09),
            gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d),
            gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b),
            gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e)
        };
    end

endmodule

// File: rtl/aes_inv_round.sv
// ---------------------------------------------------------------------------
// aes_inv_round
// One combinational inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (unless last)
// Ports:
//   state_in  - in,  128: state entering the round
//   round_key - in,  128: round key k(r)
//   last      - in,  1:   final round, skip InvMixColumns
//   state_out - out, 128: state leaving the round
// ---------------------------------------------------------------------------
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] shifted_sub;
    logic [127:0] keyed;
    logic [127:0] mixed;

    // Row r is rotated right by r, so output (r,c) takes input (r,(c-r) mod 4).
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign shifted_sub[127-8*(4*c+r) -: 8] =
                inv_sbox(get_byte(state_in, 4*((c-r+4)%4) + r));
        end
    end

    assign keyed = shifted_sub ^ round_key;

    aes_inv_mix_columns u_mix (
        .data_in  (keyed),
        .data_out (mixed)
    );

    assign state_out = last ? keyed : mixed;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_iter
// Iterative AES-128 inverse cipher, one round per clock. Round keys are
// derived backwards on the fly from the round-10 key held in key_reg.
// Optional feature macro: AES_DEC_KEY_FWD_EN -- key_in is the cipher key and
// a KEXP phase of 10 forward expansion cycles first produces the round-10 key.
// Ports:
//   clk       - in,  1:   clock, rising edge
//   reset_n   - in,  1:   asynchronous active-low reset
//   in_valid  - in,  1:   cipher_in/key_in valid
//   in_ready  - out, 1:   idle, will accept
//   cipher_in - in,  128: ciphertext, byte 0 at [127:120]
//   key_in    - in,  128: round-10 key (cipher key with AES_DEC_KEY_FWD_EN)
//   out_valid - out, 1:   plain_out valid
//   out_ready - in,  1:   consumer takes plain_out
//   plain_out - out, 128: plaintext
// ---------------------------------------------------------------------------
module aes_inv_cipher_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain_out
);

    aes_state_t   fsm;
    aes_state_t   fsm_next;
    logic [127:0] data_reg;
    logic [127:0] key_reg;
    logic [3:0]   rnd;
    logic [127:0] round_key;
    logic [127:0] round_out;
    logic         last_round;

    // key_reg holds k(rnd+1) during ROUND, so k(rnd) needs Rcon[rnd+1].
    assign last_round = (rnd == 4'd0);
    assign round_key  = inv_key_step(key_reg, rcon(rnd + 4'd1));

    aes_inv_round u_round (
        .state_in  (data_reg),
        .round_key (round_key),
        .last      (last_round),
        .state_out (round_out)
    );

`ifdef AES_DEC_KEY_FWD_EN
    // During KEXP rnd counts 1..10 and selects the forward round constant.
    logic [127:0] fwd_key;
    assign fwd_key = fwd_key_step(key_reg, rcon(rnd));
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Next-state logic. A simultaneous in_valid in DONE is not seen until IDLE.
    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE: begin
                if (in_valid) begin
`ifdef AES_DEC_KEY_FWD_EN
                    fsm_next = KEXP;
`else
                    fsm_next = ROUND;
`endif
                end
            end
`ifdef AES_DEC_KEY_FWD_EN
            KEXP: begin
                if (rnd == 4'd10) fsm_next = ROUND;
            end
`endif
            ROUND: begin
                if (last_round) fsm_next = DONE;
            end
            DONE: begin
                if (out_ready) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign plain_out = data_reg;

    // Datapath: inputs are captured only at acceptance; data_reg is frozen in
    // DONE so plain_out stays stable under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= '0;
            key_reg  <= '0;
            rnd      <= 4'd0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
`ifdef AES_DEC_KEY_FWD_EN
                        data_reg <= cipher_in;
                        key_reg  <= key_in;
                        rnd      <= 4'd1;
`else
                        data_reg <= cipher_in ^ key_in;
                        key_reg  <= key_in;
                        rnd      <= 4'd9;
`endif
                    end
                end
`ifdef AES_DEC_KEY_FWD_EN
                KEXP: begin
                    key_reg <= fwd_key;
                    if (rnd == 4'd10) begin
                        data_reg <= data_reg ^ fwd_key;
                        rnd      <= 4'd9;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
`endif
                ROUND: begin
                    data_reg <= round_out;
                    key_reg  <= round_key;
                    if (!last_round) rnd <= rnd - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_cipher_iter
// Scoreboard bench for aes_inv_cipher_iter using the FIPS-197 C.1 and B
// vectors: latency, backpressure, reset abort and back-to-back operation.
// Honours AES_DEC_KEY_FWD_EN by switching to cipher keys and 20-cycle latency.
// ---------------------------------------------------------------------------
module tb_aes_inv_cipher_iter;

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_DEC_KEY_FWD_EN
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam int           LAT    = 20;
`else
    localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam int           LAT    = 10;
`endif
    localparam int PERIOD = LAT + 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] cipher_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plain_out;

    logic [127:0] exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           accept_cyc = 0;
    int           lat;
    int           prev;

    aes_inv_cipher_iter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cipher_in (cipher_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .plain_out (plain_out)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present one block, wait for acceptance, push its expected plaintext.
    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] key,
                                 input logic [127:0] pt, input bit keep);
        bit accepted;
        accepted  = 1'b0;
        in_valid  = 1'b1;
        cipher_in = ct;
        key_in    = key;
        for (int n = 0; n < 200 && !accepted; n++) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
        end
        if (!accepted) begin
            checkOutput("accept_timeout", 128'(accepted), 128'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(pt);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        if (!keep) begin
            in_valid  = 1'b0;
            cipher_in = {4{$urandom}};
            key_in    = {4{$urandom}};
        end
    endtask

    // Count active edges from acceptance until out_valid rises.
    task automatic waitOutValid(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 5) checkOutput("busy_in_ready", 128'(in_ready), 128'd0);
            if (out_valid) break;
        end
    endtask

    task automatic waitDrain(input string tag);
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        checkOutput(tag, 128'(exp_q.size()), 128'd0);
    endtask

    // Scoreboard: every output handshake pops and compares one expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) checkOutput("spurious_out", 128'(exp_q.size()), 128'd1);
            else                   checkOutput("plain_out", plain_out, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cipher_in = '0;
        key_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 128'(in_ready), 128'd1);
        checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
        checkOutput("rst_plain_out", plain_out, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] C.1 vector with latency and backpressure");
        applyStimulus(C1_CT, C1_KEY, C1_PT, 1'b0);
        waitOutValid(lat);
        checkOutput("latency_c1", 128'(lat), 128'(LAT));
        for (int i = 0; i < 15; i++) begin
            checkOutput("bp_plain_out", plain_out, C1_PT);
            checkOutput("bp_in_ready", 128'(in_ready), 128'd0);
            checkOutput("bp_out_valid", 128'(out_valid), 128'd1);
            in_valid  = i[0];
            cipher_in = {4{$urandom}};
            key_in    = {4{$urandom}};
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("post_hs_in_ready", 128'(in_ready), 128'd1);
        checkOutput("post_hs_out_valid", 128'(out_valid), 128'd0);
        checkOutput("drain_c1", 128'(exp_q.size()), 128'd0);

        $display("[TB] B vector");
        out_ready = 1'b1;
        applyStimulus(B_CT, B_KEY, B_PT, 1'b0);
        waitOutValid(lat);
        checkOutput("latency_b", 128'(lat), 128'(LAT));
        waitDrain("drain_b");

        $display("[TB] reset abort");
        applyStimulus(C1_CT, C1_KEY, C1_PT, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("abort_out_valid", 128'(out_valid), 128'd0);
        checkOutput("abort_plain_out", plain_out, 128'd0);
        checkOutput("abort_in_ready", 128'(in_ready), 128'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort_hold_plain_out", plain_out, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(C1_CT, C1_KEY, C1_PT, 1'b0);
        waitDrain("drain_after_abort");

        $display("[TB] back-to-back");
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            prev = accept_cyc;
            if (i % 2 == 0) applyStimulus(C1_CT, C1_KEY, C1_PT, 1'b1);
            else            applyStimulus(B_CT, B_KEY, B_PT, 1'b1);
            if (i > 0) checkOutput("b2b_interval", 128'(accept_cyc - prev), 128'(PERIOD));
        end
        in_valid = 1'b0;
        waitDrain("drain_b2b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

- Iterative AES-128 inverse cipher: accepts one 128-bit ciphertext plus a key, runs one decryption round per clock, returns the 128-bit plaintext.
- Receive side of the AES datapath, paired with the MixColumns/InvMixColumns round logic.
- Derives round keys backwards on the fly from the round-10 key, so no expanded-key storage is needed.
- Valid/ready handshake on both input and output.

## Interface
Parameters: none.

Ports:
- `clk` — in, 1: single clock, rising edge.
- `reset_n` — in, 1: reset, asynchronous and active-low.
- `in_valid` — in, 1: `cipher_in`/`key_in` valid.
- `in_ready` — out, 1: block idle, will accept.
- `cipher_in` — in, 128: ciphertext; byte 0 (row 0, col 0) at [127:120]; column c occupies [127-32c -: 32].
- `key_in` — in, 128: round-10 key (cipher key when `AES_DEC_KEY_FWD_EN`); same byte order.
- `out_valid` — out, 1: `plain_out` valid.
- `out_ready` — in, 1: consumer takes `plain_out`.
- `plain_out` — out, 128: plaintext; same byte order.

## Operation
- States: `IDLE`, `KEXP` (only with `AES_DEC_KEY_FWD_EN`), `ROUND`, `DONE`. 4-bit round counter `rnd`.
- `IDLE`: `in_ready`=1. On `in_valid && in_ready`:
  - state reg <= `cipher_in ^ key_in`; key reg <= `key_in`; `rnd` <= 9; go to `ROUND`.
- `ROUND`, one clock per round:
  - Inverse key step from k(r+1) = {w4,w5,w6,w7}: w3'=w7^w6, w2'=w6^w5, w1'=w5^w4, w0'=w4^SubWord(RotWord(w3'))^Rcon[r+1].
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 in the top byte.
  - `rnd`≥1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ k(r)).
  - `rnd`=0: state <= InvSubBytes(InvShiftRows(state)) ^ k0; go to `DONE`.
  - Otherwise `rnd` decrements.
- `DONE`: `out_valid`=1, `plain_out`=state reg held stable. On `out_ready`, go to `IDLE`.
- Backpressure: `DONE` persists indefinitely; `plain_out` is unchanged while waiting.
- `in_valid` outside `IDLE` is ignored; inputs are sampled only at acceptance.
- All GF(2^8) arithmetic is mod x^8+x^4+x^3+x+1. All XOR operations are full 128-bit; no carries.

## Timing
- Reset (async assert, sync deassert by the clock domain):
  - state `IDLE`, `rnd`=0, state/key regs=0.
  - `out_valid`=0, `plain_out`=0, `in_ready`=1.
- Latency, `AES_DEC_KEY_FWD_EN` undefined:
  - Acceptance edge E0; rounds at E1..E10; `out_valid` high from E10.
  - Earliest next acceptance: one cycle after the `out_ready` handshake edge. Throughput 1 block / 12 cycles with `out_ready` tied 1.
- `in_ready` and `out_valid` are decodes of state only; neither depends combinationally on `in_valid` or `out_ready`.
- `reset_n` low mid-operation: immediate abort to reset values; the partial result is never output.
- Simultaneous `out_ready` in `DONE` and `in_valid`: the output is consumed; the input waits for `IDLE`.

## Configuration
- `AES_DEC_KEY_FWD_EN` defined:
  - `key_in` is the cipher key.
  - Acceptance loads state <= `cipher_in` and key <= `key_in`, then enters `KEXP`.
  - `KEXP` runs 10 forward expansion cycles using Rcon[1..10]. The last cycle also performs state <= state ^ k10, then goes to `ROUND` with `rnd`=9.
  - Latency: 20 cycles.
- Undefined: `KEXP` and forward expansion logic are absent; `key_in` must be the round-10 key.

## Structure
- Shared package `aes_pkg`:
  - `sbox`/`inv_sbox` functions.
  - Rcon table.
  - `gf_mul2` function.
  - State enum.
  - Byte/column index helpers.
- One combinational sub-module `aes_inv_round`: InvShiftRows → InvSubBytes → AddRoundKey → optional InvMixColumns.
  - Input `last` bypasses InvMixColumns.
  - InvMixColumns is instantiated inside it.
- Inverse key step is a package function; no separate module.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: `cipher_in`=69c4e0d86a7b0430d8cdb78070b4c55a, `key_in`=13111d7fe3944a17f307a78b4d2b30c5.
  - Response: `plain_out`=00112233445566778899aabbccddeeff, `out_valid` at E10.
- FIPS-197 B vector:
  - Stimulus: `cipher_in`=3925841d02dc09fbdc118597196a0b32, `key_in`=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Response: `plain_out`=3243f6a8885a308d313198a2e0370734.
- Backpressure:
  - Stimulus: `out_ready`=0 for 15 cycles after `out_valid`.
  - Response: `plain_out` stable; `in_ready`=0 throughout; `in_valid` pulses ignored.
- Reset abort:
  - Stimulus: `reset_n` low at E5, then rerun the C.1 vector.
  - Response: outputs 0 during reset; correct C.1 result afterward.
- Back-to-back:
  - Stimulus: `out_ready`=1, `in_valid`=1 continuously with alternating C.1/B vectors.
  - Response: correct results every 12 cycles.
- With `AES_DEC_KEY_FWD_EN`:
  - Stimulus: `key_in`=000102030405060708090a0b0c0d0e0f with the C.1 ciphertext.
  - Response: 00112233445566778899aabbccddeeff at E20.
